// File: rtl/rshp_pkg.sv
// Shared reshaper helpers: beat geometry and byte-count clamping.
package rshp_pkg;

   localparam int RSHP_DW_DEFAULT    = 512;
   localparam int RSHP_DEPTH_DEFAULT = 4;

   function automatic int rshp_nb(input int dw);
      return dw / 8;
   endfunction

   function automatic int rshp_bcw(input int dw);
      return $clog2(dw / 8) + 1;
   endfunction

   function automatic int rshp_clamp_nb(input int cnt, input int nb);
      return (cnt > nb) ? nb : cnt;
   endfunction

endpackage

// File: rtl/rshp_vbfifo_if.sv
// Write/read handshake bundle for rshp_vbfifo; slave is the FIFO side.
interface rshp_vbfifo_if #(
   parameter int DW = 512
) ();
   localparam int BW = $clog2(DW / 8) + 1;

   logic          wvalid;
   logic [BW-1:0] wbyte;
   logic [DW-1:0] wdata;
   logic          wready;
   logic          rreq;
   logic [BW-1:0] rbyte;
   logic          rgnt;
   logic [DW-1:0] rdata;
   logic          rvld;

   modport master (
      output wvalid, wbyte, wdata, rreq, rbyte,
      input  wready, rgnt, rdata, rvld
   );

   modport slave (
      input  wvalid, wbyte, wdata, rreq, rbyte,
      output wready, rgnt, rdata, rvld
   );
endinterface

// File: rtl/rshp_byte_rot.sv
// Lane barrel rotator: dout lane i = din lane (i - shift) mod LANES, for i < OUT_LANES.
module rshp_byte_rot #(
   parameter int LANES     = 8,
   parameter int LANE_W    = 8,
   parameter int OUT_LANES = 8
) (
   input  logic [LANES*LANE_W-1:0]     din,
   input  logic [$clog2(LANES)-1:0]    shift,
   output logic [OUT_LANES*LANE_W-1:0] dout
);
   localparam int SW = $clog2(LANES);

   logic [SW-1:0] src;

   // The subtraction is held in SW bits so the index wraps at LANES.
   always_comb begin
      dout = '0;
      src  = '0;
      for (int i = 0; i < OUT_LANES; i++) begin
         src = SW'(i) - shift;
         dout[i*LANE_W +: LANE_W] = din[src*LANE_W +: LANE_W];
      end
   end
endmodule

// File: rtl/rshp_vbfifo.sv
// rshp_vbfifo: byte-granular circular FIFO with handshake, flush and sticky errors.
// Define RSHP_VBFIFO_ZFILL_EN to zero rdata bytes at index >= rbyte.
module rshp_vbfifo
   import rshp_pkg::*;
#(
   parameter int DW    = RSHP_DW_DEFAULT,
   parameter int DEPTH = RSHP_DEPTH_DEFAULT
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 flush,
   rshp_vbfifo_if.slave                         bus,
   output logic [$clog2((DW/8)*DEPTH):0]        level,
   output logic                                 full,
   output logic                                 empty,
   output logic                                 ovf_err,
   output logic                                 udf_err
);
   localparam int NB = rshp_nb(DW);
   localparam int BW = rshp_bcw(DW);
   localparam int BB = NB * DEPTH;
   localparam int PW = $clog2(BB);
   localparam int LW = PW + 1;

   logic [BW-1:0]   wb;
   logic [BW-1:0]   rb;
   logic [PW-1:0]   wptr;
   logic [PW-1:0]   rptr;
   logic [PW-1:0]   rshift;
   logic [BB*8-1:0] mem_q;
   logic [BB*9-1:0] wlanes;
   logic [BB*9-1:0] wlanes_rot;
   logic [DW-1:0]   rwin;
   logic [DW-1:0]   rnext;
   logic [DW-1:0]   rdata_q;
   logic            rvld_q;
   logic            wacc;
   logic [LW-1:0]   level_next;

   assign wb = BW'(rshp_clamp_nb(int'(bus.wbyte), NB));
   assign rb = BW'(rshp_clamp_nb(int'(bus.rbyte), NB));

   assign bus.wready = (level <= LW'(BB - NB));
   assign full       = ~bus.wready;
   assign empty      = (level == '0);
   assign wacc       = bus.wvalid & bus.wready & ~flush;
   assign bus.rgnt   = bus.rreq & (level >= LW'(rb)) & ~flush;
   assign bus.rdata  = rdata_q;
   assign bus.rvld   = rvld_q;

   // Each write lane carries its enable bit so data and mask rotate together.
   always_comb begin
      wlanes = '0;
      for (int i = 0; i < NB; i++) begin
         wlanes[i*9 +: 9] = {(BW'(i) < wb), bus.wdata[i*8 +: 8]};
      end
   end

   rshp_byte_rot #(.LANES(BB), .LANE_W(9), .OUT_LANES(BB)) u_rot_wr (
      .din   (wlanes),
      .shift (wptr),
      .dout  (wlanes_rot)
   );

   assign rshift = -rptr;

   rshp_byte_rot #(.LANES(BB), .LANE_W(8), .OUT_LANES(NB)) u_rot_rd (
      .din   (mem_q),
      .shift (rshift),
      .dout  (rwin)
   );

   always_comb begin
      rnext = rwin;
`ifdef RSHP_VBFIFO_ZFILL_EN
      for (int i = 0; i < NB; i++) begin
         if (BW'(i) >= rb) rnext[i*8 +: 8] = 8'h00;
      end
`endif
   end

   // Modular LW-bit arithmetic gives the exact result since level never leaves 0..BB.
   always_comb begin
      level_next = level;
      if (wacc)     level_next = level_next + LW'(wb);
      if (bus.rgnt) level_next = level_next - LW'(rb);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr    <= '0;
         rptr    <= '0;
         level   <= '0;
         mem_q   <= '0;
         rdata_q <= '0;
         rvld_q  <= 1'b0;
         ovf_err <= 1'b0;
         udf_err <= 1'b0;
      end else begin
         if (flush) begin
            wptr   <= '0;
            rptr   <= '0;
            level  <= '0;
            rvld_q <= 1'b0;
         end else begin
            if (wacc) wptr <= wptr + PW'(wb);
            if (bus.rgnt) begin
               rptr    <= rptr + PW'(rb);
               rdata_q <= rnext;
            end
            rvld_q <= bus.rgnt;
            level  <= level_next;
            for (int j = 0; j < BB; j++) begin
               if (wacc && wlanes_rot[j*9+8]) mem_q[j*8 +: 8] <= wlanes_rot[j*9 +: 8];
            end
         end
         if (bus.wvalid && !bus.wready)           ovf_err <= 1'b1;
         if (bus.rreq && !bus.rgnt && !flush)     udf_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_rshp_vbfifo.sv
// Directed scoreboard bench for rshp_vbfifo at DW=32, DEPTH=2 (NB=4, BB=8).
module tb_rshp_vbfifo;
   localparam int DW    = 32;
   localparam int DEPTH = 2;
   localparam int LW    = 4;
`ifdef RSHP_VBFIFO_ZFILL_EN
   localparam bit ZF = 1'b1;
`else
   localparam bit ZF = 1'b0;
`endif

   logic          clk     = 1'b0;
   logic          reset_n = 1'b0;
   logic          flush   = 1'b0;
   logic [LW-1:0] level;
   logic          full;
   logic          empty;
   logic          ovf_err;
   logic          udf_err;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [31:0]   exp_q[$];
   logic [31:0]   mon_exp;

   rshp_vbfifo_if #(.DW(DW)) bus ();

   rshp_vbfifo #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .bus     (bus),
      .level   (level),
      .full    (full),
      .empty   (empty),
      .ovf_err (ovf_err),
      .udf_err (udf_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic wv, input logic [2:0] wb, input logic [31:0] wd,
                                input logic rr, input logic [2:0] rb, input logic fl,
                                input logic push, input logic [31:0] exp);
      bus.wvalid = wv;
      bus.wbyte  = wb;
      bus.wdata  = wd;
      bus.rreq   = rr;
      bus.rbyte  = rb;
      flush      = fl;
      if (push) exp_q.push_back(exp);
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      bus.wvalid = 1'b0;
      bus.wbyte  = '0;
      bus.rreq   = 1'b0;
      bus.rbyte  = '0;
      flush      = 1'b0;
   endtask

   // Every rvld must match the oldest queued expectation.
   always @(negedge clk) begin
      if (reset_n && bus.rvld) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL rdata_unexpected: got rvld with 0x%08h, expected no read", bus.rdata);
         end else begin
            mon_exp = exp_q.pop_front();
            checkOutput("rdata", bus.rdata, mon_exp);
         end
      end
   end

   initial begin
      bus.wvalid = 1'b0;
      bus.wbyte  = '0;
      bus.wdata  = '0;
      bus.rreq   = 1'b0;
      bus.rbyte  = '0;
      #12;
      checkOutput("rst_level",  level,      0);
      checkOutput("rst_wready", bus.wready, 1);
      checkOutput("rst_full",   full,       0);
      checkOutput("rst_empty",  empty,      1);
      checkOutput("rst_ovf",    ovf_err,    0);
      checkOutput("rst_udf",    udf_err,    0);
      checkOutput("rst_rvld",   bus.rvld,   0);
      checkOutput("rst_rdata",  bus.rdata,  0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic write of three bytes then read them back; byte 3 is masked off.
      applyStimulus(1, 3, 32'hDD0C0B0A, 0, 0, 0, 0, 0);
      tick();
      checkOutput("basic_level_w", level, 3);
      applyStimulus(0, 0, 0, 1, 3, 0, 1, 32'h000C0B0A);
      checkOutput("basic_rgnt", bus.rgnt, 1);
      tick();
      checkOutput("basic_level_r", level, 0);
      checkOutput("basic_empty", empty, 1);

      // Back-pressure: 4 + 2 bytes fill past BB-NB.
      applyStimulus(1, 4, 32'h44332211, 0, 0, 0, 0, 0);
      tick();
      applyStimulus(1, 2, 32'hFFEE6655, 0, 0, 0, 0, 0);
      tick();
      checkOutput("bp_level", level, 6);
      checkOutput("bp_full", full, 1);
      checkOutput("bp_wready", bus.wready, 0);
      applyStimulus(1, 1, 32'h00000077, 0, 0, 0, 0, 0);
      tick();
      checkOutput("ovf_flag", ovf_err, 1);
      checkOutput("ovf_level", level, 6);

      // First read of four from rptr=3.
      applyStimulus(0, 0, 0, 1, 4, 0, 1, 32'h44332211);
      tick();
      checkOutput("wrap_level1", level, 2);

      // Underflow: ask for 3 with only 2 stored.
      applyStimulus(0, 0, 0, 1, 3, 0, 0, 0);
      checkOutput("udf_rgnt", bus.rgnt, 0);
      tick();
      checkOutput("udf_flag", udf_err, 1);
      checkOutput("udf_rvld", bus.rvld, 0);
      checkOutput("udf_level", level, 2);

      // Refill and read four straddling index 7 -> 0.
      applyStimulus(1, 2, 32'h00009988, 0, 0, 0, 0, 0);
      tick();
      checkOutput("wrap_level2", level, 4);
      applyStimulus(0, 0, 0, 1, 4, 0, 1, 32'h99886655);
      tick();
      checkOutput("wrap_level3", level, 0);

      // Simultaneous write 2 / read 3 at level 4; read sees pre-write bytes.
      applyStimulus(1, 4, 32'hA4A3A2A1, 0, 0, 0, 0, 0);
      tick();
      checkOutput("sim_level_pre", level, 4);
      applyStimulus(1, 2, 32'h0000B2B1, 1, 3, 0, 1, ZF ? 32'h00A3A2A1 : 32'hA4A3A2A1);
      tick();
      checkOutput("sim_level", level, 3);

      // Flush with a write pending: write dropped, errors stay sticky.
      applyStimulus(1, 4, 32'hC4C3C2C1, 0, 0, 1, 0, 0);
      tick();
      checkOutput("flush_level", level, 0);
      checkOutput("flush_empty", empty, 1);
      checkOutput("flush_ovf_sticky", ovf_err, 1);
      checkOutput("flush_udf_sticky", udf_err, 1);
      applyStimulus(0, 0, 0, 1, 0, 0, 1, ZF ? 32'h00000000 : 32'hA19988B2);
      checkOutput("zero_rgnt", bus.rgnt, 1);
      tick();
      checkOutput("zero_level", level, 0);

      // Zero-fill case: read 1 byte from level 4.
      applyStimulus(1, 4, 32'hD4D3D2D1, 0, 0, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 1, 1, 0, 1, ZF ? 32'h000000D1 : 32'hD4D3D2D1);
      tick();
      checkOutput("zf_level", level, 3);

      // Out-of-range byte counts clamp to NB.
      applyStimulus(1, 7, 32'hE4E3E2E1, 0, 0, 0, 0, 0);
      tick();
      checkOutput("clamp_level_w", level, 7);
      checkOutput("clamp_full", full, 1);
      applyStimulus(0, 0, 0, 1, 6, 0, 1, 32'hE1D4D3D2);
      tick();
      checkOutput("clamp_level_r", level, 3);

      // Asynchronous reset while rvld is high.
      applyStimulus(0, 0, 0, 1, 2, 0, 0, 0);
      tick();
      checkOutput("ar_rvld_pre", bus.rvld, 1);
      #1 reset_n = 1'b0;
      #1;
      checkOutput("ar_rvld", bus.rvld, 0);
      checkOutput("ar_level", level, 0);
      checkOutput("ar_rdata", bus.rdata, 0);
      checkOutput("ar_ovf", ovf_err, 0);
      checkOutput("ar_udf", udf_err, 0);
      checkOutput("ar_empty", empty, 1);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("sb_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
